// File: rtl/serial_adder.sv
// Bit-serial adder: one registered full-adder cell, LSB first, WIDTH cycles per operation.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the 'sub' input).
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   b_load;
  logic               carry_load;
  logic               bit_s;
  logic               bit_c;

  // Subtraction is a + ~b + 1: invert b and force the initial carry.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  assign bit_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign bit_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned (no latches).
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_sr_d  = a;
          b_sr_d  = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        res_d   = {bit_s, res_q[WIDTH-1:1]};
        carry_d = bit_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // Last bit: publish the result together with the final carry.
          state_d = IDLE;
          sum_d   = {bit_s, res_q[WIDTH-1:1]};
          cout_d  = bit_c;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder against an arithmetic reference model.
// Covers reset, directed corner cases, ignored starts, back-to-back and mid-operation reset.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks = 0;
  int failures = 0;

  // Model of the visible result registers.
  logic [WIDTH-1:0] exp_sum = '0;
  logic             exp_cout = 1'b0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sum"}, sum, 0);
    check({tag, "_cout"}, cout, 0);
  endtask

  // Reference result: plain integer arithmetic on a WIDTH+1 bit value.
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                       input logic mcin, input logic msub,
                       output logic [WIDTH-1:0] rs, output logic rc);
    logic [WIDTH:0] total;
    if (msub) total = {1'b0, ma} + {1'b0, ~mb} + 1;
    else      total = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mcin};
    rs = total[WIDTH-1:0];
    rc = total[WIDTH];
  endtask

  // One full operation. Start is driven at the negedge before the accepting edge.
  // inject_busy_start pulses a bogus start with a=b=FF during busy cycle 3.
  task automatic run_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                        input logic ocin, input logic osub, input bit inject_busy_start);
    logic [WIDTH-1:0] new_sum;
    logic             new_cout;
    model(oa, ob, ocin, osub, new_sum, new_cout);
    @(negedge clk);
    a = oa; b = ob; cin = ocin; sub = osub; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    for (int i = 0; i < WIDTH; i++) begin
      check("busy_during_op", busy, 1);
      check("done_during_op", done, 0);
      check("sum_stable", sum, exp_sum);
      check("cout_stable", cout, exp_cout);
      if (inject_busy_start && i == 3) begin
        start = 1'b1; a = '1; b = '1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    exp_sum = new_sum;
    exp_cout = new_cout;
    check("busy_at_done", busy, 0);
    check("done_pulse", done, 1);
    check("sum_result", sum, exp_sum);
    check("cout_result", cout, exp_cout);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_sum_hold", sum, exp_sum);
      check("idle_cout_hold", cout, exp_cout);
    end
  endtask

  initial begin
    // Reset state, both during and after reset.
    #12;
    check_outputs_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);
    check_outputs_zero("after_reset");

    // Directed cases.
    run_op(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    idle_cycles(2);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    idle_cycles(1);
    run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
    idle_cycles(1);
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    check("ignored_start_sum", sum, 8'h46);
    // Start during the done cycle: next op accepted right away.
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
    check("b2b_sum", sum, 8'h00);
    check("b2b_cout", cout, 1);
    idle_cycles(3);

    // Asynchronous reset in cycle 4 of an operation.
    @(negedge clk);
    a = 8'h3C; b = 8'h4D; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    exp_sum = '0;
    exp_cout = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(WIDTH + 2);
    run_op(8'h3C, 8'h4D, 1'b1, 1'b0, 1'b0);
    idle_cycles(1);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
    check("sub_neg_sum", sum, 8'hFE);
    check("sub_neg_cout", cout, 0);
    run_op(8'h07, 8'h05, 1'b1, 1'b1, 1'b0);
    check("sub_pos_sum", sum, 8'h02);
    check("sub_pos_cout", cout, 1);
    idle_cycles(1);
`endif

    // Randomized operations with random gaps (0 = back-to-back).
    for (int n = 0; n < 40; n++) begin
      logic rs;
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), rs, ($urandom_range(0, 3) == 0));
      idle_cycles($urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
